// File: rtl/lif_pkg.sv
// lif_pkg: shared constants, result-record type and saturating add for the
// LIF neuron array (lif_array, lif_update_core).
package lif_pkg;

  // Default configuration.
  localparam int unsigned LIF_N_CH      = 4;
  localparam int unsigned LIF_W         = 8;
  localparam int unsigned LIF_FRAC      = 8;
  localparam int unsigned LIF_THR_INIT  = 100;
  localparam int unsigned LIF_BETA_INIT = 224;
  localparam int unsigned LIF_INC       = 295;
  localparam int unsigned LIF_DEC       = 244;
  localparam int unsigned LIF_THR_MAX   = 220;
  localparam int unsigned LIF_THR_MIN   = 8;
  localparam int unsigned LIF_BETA_MAX  = 220;
  localparam int unsigned LIF_BETA_MIN  = 128;
  localparam int unsigned LIF_REFRAC    = 2;

  // Record fields are sized for the widest supported configuration;
  // lif_array uses the low CW / W bits.
  localparam int unsigned LIF_REC_CW = 8;
  localparam int unsigned LIF_REC_W  = 16;

  typedef struct packed {
    logic [LIF_REC_CW-1:0] ch;
    logic [LIF_REC_W-1:0]  state;
    logic                  spike;
  } lif_rec_t;

  // Unsigned a+b clamped to 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'(1) << w) - 33'(1);
    return (sum > lim) ? 32'(lim) : 32'(sum);
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// lif_update_core: combinational single-neuron LIF update.
// Inputs : s_i/t_i/b_i (pre-update state, threshold, beta), r_i (refractory
//          count, only with LIF_REFRACTORY_EN), cur_i, learn_thr_i, learn_beta_i.
// Outputs: new_s_c_o/new_t_c_o/new_b_c_o/new_r_c_o next values, spike_c_o.
// Macro  : LIF_REFRACTORY_EN adds the refractory counter path.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int unsigned W        = LIF_W,
  parameter int unsigned FRAC     = LIF_FRAC,
  parameter int unsigned INC      = LIF_INC,
  parameter int unsigned DEC      = LIF_DEC,
  parameter int unsigned THR_MAX  = LIF_THR_MAX,
  parameter int unsigned THR_MIN  = LIF_THR_MIN,
  parameter int unsigned BETA_MAX = LIF_BETA_MAX,
  parameter int unsigned BETA_MIN = LIF_BETA_MIN
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int unsigned REFRAC   = LIF_REFRAC,
  parameter int unsigned RW       = 2
`endif
) (
  input  logic [W-1:0]    s_i,
  input  logic [W-1:0]    t_i,
  input  logic [FRAC-1:0] b_i,
`ifdef LIF_REFRACTORY_EN
  input  logic [RW-1:0]   r_i,
  output logic [RW-1:0]   new_r_c_o,
`endif
  input  logic [W-1:0]    cur_i,
  input  logic            learn_thr_i,
  input  logic            learn_beta_i,
  output logic [W-1:0]    new_s_c_o,
  output logic [W-1:0]    new_t_c_o,
  output logic [FRAC-1:0] new_b_c_o,
  output logic            spike_c_o
);

  localparam int unsigned PW = W + FRAC;
  localparam int unsigned TW = W + 9;
  localparam int unsigned BW = FRAC + 9;

  localparam logic [W-1:0]    THR_MAX_V  = W'(THR_MAX);
  localparam logic [W-1:0]    THR_MIN_V  = W'(THR_MIN);
  localparam logic [FRAC-1:0] BETA_MAX_V = FRAC'(BETA_MAX);
  localparam logic [FRAC-1:0] BETA_MIN_V = FRAC'(BETA_MIN);

  logic [PW-1:0] leak_prod;
  logic [W-1:0]  leak;
  logic [W-1:0]  integ;
  logic [TW-1:0] t_up_prod;
  logic [TW-1:0] t_dn_prod;
  logic [BW-1:0] b_up_prod;
  logic [BW-1:0] b_dn_prod;

  // Full-width products, truncated by the fixed-point shift.
  assign leak_prod = PW'(s_i) * PW'(b_i);
  assign leak      = W'(leak_prod >> FRAC);
  assign integ     = W'(sat_add(32'(cur_i), 32'(leak), W));
  assign t_up_prod = TW'(t_i) * TW'(INC);
  assign t_dn_prod = TW'(t_i) * TW'(DEC);
  assign b_up_prod = BW'(b_i) * BW'(INC);
  assign b_dn_prod = BW'(b_i) * BW'(DEC);

  // Refractory > fire > integrate.
  always_comb begin
    new_s_c_o = s_i;
    new_t_c_o = t_i;
    new_b_c_o = b_i;
    spike_c_o = 1'b0;
`ifdef LIF_REFRACTORY_EN
    new_r_c_o = r_i;
    if (r_i != '0) begin
      new_s_c_o = '0;
      new_r_c_o = r_i - RW'(1);
    end else
`endif
    if (s_i >= t_i) begin
      new_s_c_o = '0;
      spike_c_o = 1'b1;
`ifdef LIF_REFRACTORY_EN
      new_r_c_o = RW'(REFRAC);
`endif
      if (learn_thr_i && (t_i < THR_MAX_V))   new_t_c_o = W'(t_up_prod >> 8);
      if (learn_beta_i && (b_i < BETA_MAX_V)) new_b_c_o = FRAC'(b_up_prod >> 8);
    end else begin
      new_s_c_o = integ;
      if (learn_thr_i && (t_i > THR_MIN_V))   new_t_c_o = W'(t_dn_prod >> 8);
      if (learn_beta_i && (b_i > BETA_MIN_V)) new_b_c_o = FRAC'(b_dn_prod >> 8);
    end
  end

endmodule

// File: rtl/lif_array.sv
// lif_array: N_CH time-multiplexed leaky integrate-and-fire neurons sharing
// one lif_update_core. Each accepted sample does a single-cycle
// read-modify-write of its channel and yields one result record.
// Ports: clk, rst_n (sync, active-low)
//        in_valid/in_ready/in_ch/in_current/learn_thr/learn_beta : sample in
//        out_valid/out_ready/out_ch/out_state/out_spike          : record out
// Macro : LIF_REFRACTORY_EN enables per-channel refractory counters.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_CH      = LIF_N_CH,
  parameter int unsigned W         = LIF_W,
  parameter int unsigned FRAC      = LIF_FRAC,
  parameter int unsigned THR_INIT  = LIF_THR_INIT,
  parameter int unsigned BETA_INIT = LIF_BETA_INIT,
  parameter int unsigned INC       = LIF_INC,
  parameter int unsigned DEC       = LIF_DEC,
  parameter int unsigned THR_MAX   = LIF_THR_MAX,
  parameter int unsigned THR_MIN   = LIF_THR_MIN,
  parameter int unsigned BETA_MAX  = LIF_BETA_MAX,
  parameter int unsigned BETA_MIN  = LIF_BETA_MIN,
  parameter int unsigned REFRAC    = LIF_REFRAC,
  localparam int unsigned CW       = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [W-1:0]  in_current,
  input  logic          learn_thr,
  input  logic          learn_beta,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_state,
  output logic          out_spike
);

  // Elaboration-time legality checks.
  if (N_CH < 2) begin : g_chk_nch
    $error("lif_array: N_CH must be at least 2");
  end
  if ((W > LIF_REC_W) || (CW > LIF_REC_CW)) begin : g_chk_rec
    $error("lif_array: W or CW exceeds record field width");
  end
  if (((THR_MAX * INC) >> 8) >= (1 << W)) begin : g_chk_thr
    $error("lif_array: THR_MAX*INC>>8 does not fit in W bits");
  end
  if (((BETA_MAX * INC) >> 8) >= (1 << FRAC)) begin : g_chk_beta
    $error("lif_array: BETA_MAX*INC>>8 does not fit in FRAC bits");
  end
  if (REFRAC > 255) begin : g_chk_refrac
    $error("lif_array: REFRAC out of range");
  end

  logic          accept_c;
  logic          ch_ok_c;
  logic [CW-1:0] idx_c;

  logic [W-1:0]    state_q [N_CH];
  logic [W-1:0]    thr_q   [N_CH];
  logic [FRAC-1:0] beta_q  [N_CH];

  logic [W-1:0]    new_s_c;
  logic [W-1:0]    new_t_c;
  logic [FRAC-1:0] new_b_c;
  logic            spike_c;

  lif_rec_t rec_d;
  lif_rec_t rec_q;
  logic     out_valid_q;
  logic     unused_rec_c;

  // Single output register, no skid: accept only when the slot frees up.
  assign in_ready = !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;
  assign ch_ok_c  = 32'(in_ch) < N_CH;
  assign idx_c    = ch_ok_c ? in_ch : '0;

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [RW-1:0] rcnt_q [N_CH];
  logic [RW-1:0] new_r_c;

  // Refractory counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) rcnt_q[i] <= '0;
    end else if (accept_c && ch_ok_c) begin
      rcnt_q[idx_c] <= new_r_c;
    end
  end
`endif

  lif_update_core #(
    .W        (W),
    .FRAC     (FRAC),
    .INC      (INC),
    .DEC      (DEC),
    .THR_MAX  (THR_MAX),
    .THR_MIN  (THR_MIN),
    .BETA_MAX (BETA_MAX),
    .BETA_MIN (BETA_MIN)
`ifdef LIF_REFRACTORY_EN
    ,
    .REFRAC   (REFRAC),
    .RW       (RW)
`endif
  ) u_core (
    .s_i          (state_q[idx_c]),
    .t_i          (thr_q[idx_c]),
    .b_i          (beta_q[idx_c]),
`ifdef LIF_REFRACTORY_EN
    .r_i          (rcnt_q[idx_c]),
    .new_r_c_o    (new_r_c),
`endif
    .cur_i        (in_current),
    .learn_thr_i  (learn_thr),
    .learn_beta_i (learn_beta),
    .new_s_c_o    (new_s_c),
    .new_t_c_o    (new_t_c),
    .new_b_c_o    (new_b_c),
    .spike_c_o    (spike_c)
  );

  // Channel storage; write-back in the accept cycle so the next sample
  // to the same channel sees the updated values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= '0;
        thr_q[i]   <= W'(THR_INIT);
        beta_q[i]  <= FRAC'(BETA_INIT);
      end
    end else if (accept_c && ch_ok_c) begin
      state_q[idx_c] <= new_s_c;
      thr_q[idx_c]   <= new_t_c;
      beta_q[idx_c]  <= new_b_c;
    end
  end

  // Out-of-range channels produce an all-zero record.
  always_comb begin
    rec_d    = '0;
    rec_d.ch = LIF_REC_CW'(in_ch);
    if (ch_ok_c) begin
      rec_d.state = LIF_REC_W'(new_s_c);
      rec_d.spike = spike_c;
    end
  end

  // Output record register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rec_q       <= '0;
    end else if (accept_c) begin
      out_valid_q <= 1'b1;
      rec_q       <= rec_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_ch       = rec_q.ch[CW-1:0];
  assign out_state    = rec_q.state[W-1:0];
  assign out_spike    = rec_q.spike;
  assign unused_rec_c = ^{rec_q.ch, rec_q.state};

endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed self-checking bench for lif_array.
// dut1 uses defaults; dut2 has N_CH=3 and THR_INIT=255 for saturation and
// out-of-range channel cases.
module tb_lif_array;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, learn_thr, learn_beta;
  logic [1:0] in_ch;
  logic [7:0] in_current;
  logic       out_valid, out_ready, out_spike;
  logic [1:0] out_ch;
  logic [7:0] out_state;

  logic       in_valid2, in_ready2, out_valid2, out_spike2;
  logic [1:0] in_ch2, out_ch2;
  logic [7:0] in_current2, out_state2;

  int n_cmp;
  int n_err;

  lif_array dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_current (in_current),
    .learn_thr  (learn_thr),
    .learn_beta (learn_beta),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_state  (out_state),
    .out_spike  (out_spike)
  );

  lif_array #(.N_CH(3), .THR_INIT(255)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_ch      (in_ch2),
    .in_current (in_current2),
    .learn_thr  (1'b0),
    .learn_beta (1'b0),
    .out_valid  (out_valid2),
    .out_ready  (1'b1),
    .out_ch     (out_ch2),
    .out_state  (out_state2),
    .out_spike  (out_spike2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One sample into dut1; returns the record visible after the accepting edge.
  task automatic drive1(input logic [1:0] ch, input logic [7:0] cur,
                        input logic lt, input logic lb,
                        output logic v, output logic [1:0] och,
                        output logic [7:0] st, output logic sp);
    in_valid = 1'b1; in_ch = ch; in_current = cur; learn_thr = lt; learn_beta = lb;
    @(posedge clk); #1;
    in_valid = 1'b0; learn_thr = 1'b0; learn_beta = 1'b0;
    v = out_valid; och = out_ch; st = out_state; sp = out_spike;
  endtask

  task automatic drive2(input logic [1:0] ch, input logic [7:0] cur,
                        output logic v, output logic [1:0] och,
                        output logic [7:0] st, output logic sp);
    in_valid2 = 1'b1; in_ch2 = ch; in_current2 = cur;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    v = out_valid2; och = out_ch2; st = out_state2; sp = out_spike2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_state !== 8'd0 || out_spike !== 1'b0) begin
      n_err++;
      $display("FAIL reset: valid=%b ch=%0d state=%0d spike=%b, required all 0", out_valid, out_ch, out_state, out_spike);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: in_ready=%b out_valid2=%b, required 1/0", in_ready, out_valid2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    int es [12];
    int esp [12];
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    do_reset();
`ifdef LIF_REFRACTORY_EN
    es = '{20, 37, 52, 65, 76, 86, 95, 103, 0, 0, 0, 20};
`else
    es = '{20, 37, 52, 65, 76, 86, 95, 103, 0, 20, 37, 52};
`endif
    esp = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      drive1(2'd0, 8'd20, 1'b0, 1'b0, v, oc, st, sp);
      n_cmp++;
      if (v !== 1'b1 || oc !== 2'd0 || st !== 8'(es[i]) || sp !== 1'(esp[i])) begin
        n_err++;
        $display("FAIL single[%0d]: valid=%b ch=%0d state=%0d spike=%b, required 1/0/%0d/%0d", i, v, oc, st, sp, es[i], esp[i]);
      end
    end
  endtask

  task automatic test_interleave();
    int ch [8];
    int cur [8];
    int es [8];
    int esp [8];
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    do_reset();
    ch  = '{0, 1, 0, 1, 0, 1, 0, 1};
    cur = '{20, 50, 20, 50, 20, 50, 20, 50};
    es  = '{20, 50, 37, 93, 52, 131, 65, 0};
    esp = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      drive1(2'(ch[i]), 8'(cur[i]), 1'b0, 1'b0, v, oc, st, sp);
      n_cmp++;
      if (v !== 1'b1 || oc !== 2'(ch[i]) || st !== 8'(es[i]) || sp !== 1'(esp[i])) begin
        n_err++;
        $display("FAIL interleave[%0d]: valid=%b ch=%0d state=%0d spike=%b, required 1/%0d/%0d/%0d", i, v, oc, st, sp, ch[i], es[i], esp[i]);
      end
    end
  endtask

  // thr 100 -> 95 on a learning integrate, 95 -> 109 on a learning spike.
  task automatic test_learn_thr();
    int cur [9];
    int lt [9];
    int es [9];
    int esp [9];
    int n;
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    do_reset();
`ifdef LIF_REFRACTORY_EN
    n   = 9;
    cur = '{10, 90, 0, 0, 0, 100, 0, 34, 0};
    lt  = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    es  = '{10, 98, 0, 0, 0, 100, 87, 110, 0};
    esp = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
`else
    n   = 7;
    cur = '{10, 90, 0, 100, 0, 34, 0, 0, 0};
    lt  = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    es  = '{10, 98, 0, 100, 87, 110, 0, 0, 0};
    esp = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
`endif
    for (int i = 0; i < n; i++) begin
      drive1(2'd2, 8'(cur[i]), 1'(lt[i]), 1'b0, v, oc, st, sp);
      n_cmp++;
      if (v !== 1'b1 || oc !== 2'd2 || st !== 8'(es[i]) || sp !== 1'(esp[i])) begin
        n_err++;
        $display("FAIL learn_thr[%0d]: valid=%b ch=%0d state=%0d spike=%b, required 1/2/%0d/%0d", i, v, oc, st, sp, es[i], esp[i]);
      end
    end
  endtask

  // beta 224 -> 213; leak of 90 then gives 74 instead of 78.
  task automatic test_learn_beta();
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    drive1(2'd3, 8'd90, 1'b0, 1'b1, v, oc, st, sp);
    n_cmp++;
    if (v !== 1'b1 || st !== 8'd90 || sp !== 1'b0) begin
      n_err++;
      $display("FAIL learn_beta_a: valid=%b state=%0d spike=%b, required 1/90/0", v, st, sp);
    end
    drive1(2'd3, 8'd0, 1'b0, 1'b0, v, oc, st, sp);
    n_cmp++;
    if (v !== 1'b1 || st !== 8'd74 || sp !== 1'b0) begin
      n_err++;
      $display("FAIL learn_beta_b: valid=%b state=%0d spike=%b, required 1/74/0", v, st, sp);
    end
  endtask

  task automatic test_backpressure();
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    do_reset();
    drive1(2'd0, 8'd20, 1'b0, 1'b0, v, oc, st, sp);
    n_cmp++;
    if (v !== 1'b1 || st !== 8'd20) begin
      n_err++;
      $display("FAIL bp_first: valid=%b state=%0d, required 1/20", v, st);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_current = 8'd20;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready: in_ready=%b, required 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ch !== 2'd0 || out_state !== 8'd20 || out_spike !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b ch=%0d state=%0d spike=%b, required 0/1/0/20/0", i, in_ready, out_valid, out_ch, out_state, out_spike);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_state !== 8'd37) begin
      n_err++;
      $display("FAIL bp_release: valid=%b state=%0d, required 1/37", out_valid, out_state);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    do_reset();
    drive1(2'd0, 8'd20, 1'b0, 1'b0, v, oc, st, sp);
    in_valid = 1'b1; in_ch = 2'd0; in_current = 8'd20;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_state !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b state=%0d, required 0/0", out_valid, out_state);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive1(2'd0, 8'd20, 1'b0, 1'b0, v, oc, st, sp);
    n_cmp++;
    if (v !== 1'b1 || st !== 8'd20) begin
      n_err++;
      $display("FAIL reset_restart: valid=%b state=%0d, required 1/20", v, st);
    end
  endtask

  task automatic test_saturation_oor();
    int es [3];
    int esp [3];
    logic v, sp; logic [1:0] oc; logic [7:0] st;
    do_reset();
    es  = '{200, 255, 0};
    esp = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      drive2(2'd1, (i < 2) ? 8'd200 : 8'd0, v, oc, st, sp);
      n_cmp++;
      if (v !== 1'b1 || oc !== 2'd1 || st !== 8'(es[i]) || sp !== 1'(esp[i])) begin
        n_err++;
        $display("FAIL saturate[%0d]: valid=%b ch=%0d state=%0d spike=%b, required 1/1/%0d/%0d", i, v, oc, st, sp, es[i], esp[i]);
      end
    end
    drive2(2'd3, 8'd50, v, oc, st, sp);
    n_cmp++;
    if (v !== 1'b1 || oc !== 2'd3 || st !== 8'd0 || sp !== 1'b0) begin
      n_err++;
      $display("FAIL out_of_range: valid=%b ch=%0d state=%0d spike=%b, required 1/3/0/0", v, oc, st, sp);
    end
    drive2(2'd2, 8'd50, v, oc, st, sp);
    n_cmp++;
    if (v !== 1'b1 || oc !== 2'd2 || st !== 8'd50 || sp !== 1'b0) begin
      n_err++;
      $display("FAIL oor_untouched: valid=%b ch=%0d state=%0d spike=%b, required 1/2/50/0", v, oc, st, sp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_ch = 2'd0; in_current = 8'd0;
    learn_thr = 1'b0; learn_beta = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_ch2 = 2'd0; in_current2 = 8'd0;
    @(posedge clk); #1;

    test_reset();
    test_single_channel();
    test_interleave();
    test_learn_thr();
    test_learn_beta();
    test_backpressure();
    test_reset_mid();
    test_saturation_oor();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
